// File: rtl/sw_irq_servicer_pkg.sv
// Shared types and constants for the switch-PIO interrupt servicer.
// FSM state encoding and the PIO register map used on the Avalon-MM side.
package sw_irq_servicer_pkg;

    typedef enum logic [2:0] {
        INIT     = 3'd0,
        IDLE     = 3'd1,
        RD_EDGE  = 3'd2,
        CAP_EDGE = 3'd3,
        CLR_EDGE = 3'd4,
        RD_DATA  = 3'd5,
        CAP_DATA = 3'd6,
        PUSH     = 3'd7
    } state_t;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    localparam int TIME_W = 32;

endpackage

// File: rtl/sw_irq_servicer_fifo.sv
// First-word-fall-through event FIFO; DEPTH must be a power of two so the
// pointers wrap naturally. A push while full is accepted only if a pop frees a slot.
module sw_irq_servicer_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_FULL);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            if (do_push && !do_pop)      count_q <= count_q + CNT_ONE;
            else if (do_pop && !do_push) count_q <= count_q - CNT_ONE;
        end
    end

endmodule

// File: rtl/sw_irq_servicer.sv
// Services a switch PIO interrupt: reads/clears the edge register, reads levels, queues events.
// Define SW_IRQ_SERVICER_TIMESTAMP_EN to stamp each event with a free-running cycle count.
module sw_irq_servicer
    import sw_irq_servicer_pkg::*;
#(
    parameter int WIDTH      = 18,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    output logic [1:0]       avm_address,
    output logic             avm_chipselect,
    output logic             avm_write_n,
    output logic [31:0]      avm_writedata,
    input  logic [31:0]      avm_readdata,
    input  logic             irq_in,
    input  logic [WIDTH-1:0] mask_cfg,
    input  logic             mask_load,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [WIDTH-1:0] evt_edges,
    output logic [WIDTH-1:0] evt_level,
    output logic [31:0]      evt_time,
    output logic             overflow,
    input  logic             overflow_clr
);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] edges_q, edges_d, level_q, level_d;
    logic [WIDTH-1:0] mask_val_q, mask_val_d;
    logic             mask_pend_q, mask_pend_d;
    logic             overflow_q, overflow_d;
    logic             bus_cs, bus_wn;
    logic [1:0]       bus_addr;
    logic [31:0]      bus_wd;
    logic             push_evt, fifo_full, fifo_empty, fifo_pop, drop;
    logic             unused_rd;

    assign unused_rd = ^(avm_readdata >> WIDTH);

    always_comb begin
        state_d     = state_q;
        edges_d     = edges_q;
        level_d     = level_q;
        mask_pend_d = mask_pend_q;
        mask_val_d  = mask_val_q;
        bus_cs      = 1'b0;
        bus_wn      = 1'b1;
        bus_addr    = '0;
        bus_wd      = '0;
        push_evt    = 1'b0;
        if (mask_load) begin
            mask_pend_d = 1'b1;
            mask_val_d  = mask_cfg;
        end
        case (state_q)
            INIT: begin
                bus_cs   = 1'b1;
                bus_wn   = 1'b0;
                bus_addr = ADDR_MASK;
                bus_wd   = 32'(mask_cfg);
                state_d  = IDLE;
            end
            IDLE: begin
                // A mask write (held or arriving now) wins over a pending irq.
                if (mask_pend_q || mask_load) begin
                    bus_cs      = 1'b1;
                    bus_wn      = 1'b0;
                    bus_addr    = ADDR_MASK;
                    bus_wd      = mask_load ? 32'(mask_cfg) : 32'(mask_val_q);
                    mask_pend_d = 1'b0;
                end else if (irq_in) begin
                    state_d = RD_EDGE;
                end
            end
            RD_EDGE: begin
                bus_cs   = 1'b1;
                bus_addr = ADDR_EDGE;
                state_d  = CAP_EDGE;
            end
            CAP_EDGE: begin
                edges_d = avm_readdata[WIDTH-1:0];
                state_d = (avm_readdata[WIDTH-1:0] == '0) ? IDLE : CLR_EDGE;
            end
            CLR_EDGE: begin
                bus_cs   = 1'b1;
                bus_wn   = 1'b0;
                bus_addr = ADDR_EDGE;
                state_d  = RD_DATA;
            end
            RD_DATA: begin
                bus_cs   = 1'b1;
                bus_addr = ADDR_DATA;
                state_d  = CAP_DATA;
            end
            CAP_DATA: begin
                level_d = avm_readdata[WIDTH-1:0];
                state_d = PUSH;
            end
            PUSH: begin
                push_evt = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= INIT;
            edges_q     <= '0;
            level_q     <= '0;
            mask_pend_q <= 1'b0;
            mask_val_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            edges_q     <= edges_d;
            level_q     <= level_d;
            mask_pend_q <= mask_pend_d;
            mask_val_q  <= mask_val_d;
            overflow_q  <= overflow_d;
        end
    end

    // Bus is held idle for the whole reset cycle even though state is already INIT.
    assign avm_chipselect = reset ? 1'b0 : bus_cs;
    assign avm_write_n    = reset ? 1'b1 : bus_wn;
    assign avm_address    = reset ? 2'd0 : bus_addr;
    assign avm_writedata  = reset ? 32'd0 : bus_wd;

    // evt_valid/evt_ready: an entry is presented while the FIFO is non-empty and
    // leaves on any clock edge where both are high; evt_* stay stable until then.
    assign fifo_pop   = evt_valid && evt_ready;
    assign drop       = push_evt && fifo_full && !fifo_pop;
    assign overflow_d = drop ? 1'b1 : (overflow_clr ? 1'b0 : overflow_q);
    assign overflow   = overflow_q;
    assign evt_valid  = !fifo_empty;

`ifdef SW_IRQ_SERVICER_TIMESTAMP_EN
    localparam int ENTRY_W = 2 * WIDTH + TIME_W;
    logic [31:0] tick_q, stamp_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_q  <= '0;
            stamp_q <= '0;
        end else begin
            tick_q <= tick_q + 32'd1;
            if (state_q == CAP_EDGE) stamp_q <= tick_q;
        end
    end
`else
    localparam int ENTRY_W = 2 * WIDTH;
`endif

    logic [ENTRY_W-1:0] fifo_din, fifo_dout;

`ifdef SW_IRQ_SERVICER_TIMESTAMP_EN
    assign fifo_din = {edges_q, level_q, stamp_q};
    assign evt_time = fifo_empty ? 32'd0 : fifo_dout[TIME_W-1:0];
`else
    assign fifo_din = {edges_q, level_q};
    assign evt_time = 32'd0;
`endif

    assign evt_edges = fifo_empty ? '0 : fifo_dout[ENTRY_W-1 -: WIDTH];
    assign evt_level = fifo_empty ? '0 : fifo_dout[ENTRY_W-WIDTH-1 -: WIDTH];

    sw_irq_servicer_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_evt),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule
